debugger_line_input: RTL and testbench
======================================

// Module: debugger_line_input
// PURPOSE
//  Debugger console line editor, upstream of the hex-parse stage. Accepts one
//  byte at a time from the UART RX path and builds a command line in DATA/LENGTH.
//  Echoes keystrokes to the UART TX path. On CR, hands the finished line to the
//  command decoder via a 4-phase active-low REQ_n/ACK_n handshake.
// PARAMETERS
//  COUNT  64  line buffer depth in bytes; LENGTH width is $clog2(COUNT+1)+1
// PORTS
//  CLK         in   1      system clock; single clock domain
//  RESET_n     in   1      asynchronous, active-low reset
//  RX_VALID    in   1      RX_DATA holds a received byte this cycle
//  RX_DATA     in   8      received character
//  RX_READY    out  1      byte accepted when RX_VALID&&RX_READY; =(state==ST_IDLE)
//  TX_REQ_n    out  1      echo request to UART TX, 4-phase, active low
//  TX_DATA     out  8      echo byte; stable while TX_REQ_n=0
//  TX_ACK_n    in   1      echo acknowledge from UART TX
//  LINE_REQ_n  out  1      line-ready request to the command decoder, active low
//  LINE_ACK_n  in   1      line acknowledge from the command decoder
//  DATA        out  8xCOUNT  line buffer DATA[0:COUNT-1]
//  LENGTH      out  $clog2(COUNT+1)+1  number of valid bytes in DATA
// BEHAVIOUR
//  Reset: state=ST_IDLE (RX_READY=1); TX_REQ_n=1, TX_DATA=0, LINE_REQ_n=1;
//   LENGTH=0; all DATA=8'h00; echo queue empty; line_pend=0.
//   An asserted RESET_n abandons any handshake in progress immediately.
//  States: ST_IDLE, ST_TX_REQ, ST_TX_REL, ST_LINE_REQ, ST_LINE_REL.
//  ST_IDLE, accepted byte c, classified in priority order:
//   - 0x20..0x7E, LENGTH<COUNT: DATA[LENGTH]<=c; LENGTH+1; echo {c}.
//   - 0x20..0x7E, LENGTH==COUNT: buffer unchanged; echo {0x07}.
//   - 0x08 or 0x7F, LENGTH>0: LENGTH-1 (byte left in DATA); echo {08,20,08}.
//   - 0x08 or 0x7F, LENGTH==0: no change, no echo; stay in ST_IDLE.
//   - 0x0D: echo {0D,0A}; set line_pend.
//   - 0x03: LENGTH<=0; echo {5E,43,0D,0A} ("^C" CRLF); no line_pend.
//   - any other byte, including 0x0A: ignored; stay in ST_IDLE.
//   If the byte queues an echo, go to ST_TX_REQ.
//  Echo queue: up to 4 bytes plus a count, loaded in the accept cycle.
//  ST_TX_REQ:
//   - Cycle after accept: TX_REQ_n=0 with TX_DATA = head of queue.
//   - On sampling TX_ACK_n=0: TX_REQ_n<=1, pop the queue, go to ST_TX_REL.
//  ST_TX_REL: wait for TX_ACK_n=1, then:
//   - queue not empty: TX_REQ_n<=0 with the next byte, go to ST_TX_REQ;
//   - else line_pend: go to ST_LINE_REQ;
//   - else: go to ST_IDLE.
//  ST_LINE_REQ:
//   - LINE_REQ_n=0 (clear line_pend).
//   - DATA and LENGTH frozen until the handshake completes.
//   - On LINE_ACK_n=0: LINE_REQ_n<=1, go to ST_LINE_REL.
//  ST_LINE_REL: on LINE_ACK_n=1: LENGTH<=0, go to ST_IDLE.
//  Boundary rules:
//   - CR with LENGTH==0 still runs the line handshake, with LENGTH=0.
//   - RX_READY=0 outside ST_IDLE; upstream must hold or drop the byte.
//   - LENGTH never exceeds COUNT and never goes below 0.
// TESTING
//  1. Send "d 10"+CR, ack promptly:
//     -> echo 64 20 31 30 0D 0A; LINE_REQ_n low with LENGTH=4, DATA[0..3]="d 10";
//        after LINE_ACK_n: LENGTH=0, RX_READY=1.
//  2. Send "ab", BS, "c", CR:
//     -> echo 61 62 08 20 08 63 0D 0A; LENGTH=2, DATA[0..1]="ac".
//  3. BS at LENGTH=0, then LF -> no TX_REQ_n activity; LENGTH stays 0.
//  4. COUNT=4; send "12345" -> fifth byte echoes 07; LENGTH=4;
//     CR -> line "1234".
//  5. Send "xy", 0x03 -> echo 78 79 5E 43 0D 0A; LENGTH=0; LINE_REQ_n stays 1.
//  6. Hold TX_ACK_n low 10 cycles; pulse RESET_n low mid-echo
//     -> TX_REQ_n=1, LENGTH=0, state ST_IDLE; no spurious LINE_REQ_n.

Source files
------------

// File: rtl/debugger_line_input.sv
// Debugger console line editor.
// Accepts bytes from the UART RX path, edits a command line in DATA/LENGTH,
// echoes keystrokes to the UART TX path over a 4-phase active-low handshake,
// and on CR hands the finished line to the command decoder over a second
// 4-phase active-low handshake.
module debugger_line_input #(
  parameter  int COUNT = 64,
  localparam int LW    = $clog2(COUNT + 1) + 1,
  localparam int IW    = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic          CLK,
  input  logic          RESET_n,
  input  logic          RX_VALID,
  input  logic [7:0]    RX_DATA,
  output logic          RX_READY,
  output logic          TX_REQ_n,
  output logic [7:0]    TX_DATA,
  input  logic          TX_ACK_n,
  output logic          LINE_REQ_n,
  input  logic          LINE_ACK_n,
  output logic [7:0]    DATA [0:COUNT-1],
  output logic [LW-1:0] LENGTH
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_REQ   = 3'd1,
    ST_TX_REL   = 3'd2,
    ST_LINE_REQ = 3'd3,
    ST_LINE_REL = 3'd4
  } state_t;

  // Character classes recognised by the editor.
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  function automatic logic is_rubout(input logic [7:0] c);
    return (c == 8'h08) || (c == 8'h7F);
  endfunction

  state_t        state_r;
  state_t        state_nxt_s;
  logic [LW-1:0] length_r;
  logic [LW-1:0] length_nxt_s;
  logic          line_pend_r;
  logic          line_pend_nxt_s;
  logic          tx_req_n_r;
  logic          tx_req_n_nxt_s;
  logic [7:0]    tx_data_r;
  logic [7:0]    tx_data_nxt_s;
  logic          line_req_n_r;
  logic          line_req_n_nxt_s;
  logic          rx_ready_r;

  // Echo queue: head always sits in q_r[0]; popping shifts towards the head.
  logic [7:0]    q_r     [0:3];
  logic [7:0]    q_nxt_s [0:3];
  logic [2:0]    q_cnt_r;
  logic [2:0]    q_cnt_nxt_s;

  // Bytes selected for echo by the character just accepted.
  logic [7:0]    ld_s [0:3];
  logic [2:0]    ld_cnt_s;

  // Line buffer write port.
  logic          wr_en_s;
  logic [IW-1:0] wr_idx_s;

  assign wr_idx_s   = length_r[IW-1:0];
  assign RX_READY   = rx_ready_r;
  assign TX_REQ_n   = tx_req_n_r;
  assign TX_DATA    = tx_data_r;
  assign LINE_REQ_n = line_req_n_r;
  assign LENGTH     = length_r;

  // Next-state, edit and handshake decisions for the current cycle.
  always_comb begin
    state_nxt_s      = state_r;
    length_nxt_s     = length_r;
    line_pend_nxt_s  = line_pend_r;
    tx_req_n_nxt_s   = tx_req_n_r;
    tx_data_nxt_s    = tx_data_r;
    line_req_n_nxt_s = line_req_n_r;
    q_cnt_nxt_s      = q_cnt_r;
    wr_en_s          = 1'b0;
    ld_cnt_s         = 3'd0;
    for (int i = 0; i < 4; i++) begin
      q_nxt_s[i] = q_r[i];
      ld_s[i]    = 8'h00;
    end

    case (state_r)
      ST_IDLE: begin
        if (RX_VALID) begin
          if (is_printable(RX_DATA)) begin
            if (length_r < LW'(COUNT)) begin
              wr_en_s      = 1'b1;
              length_nxt_s = length_r + LW'(1);
              ld_s[0]      = RX_DATA;
              ld_cnt_s     = 3'd1;
            end else begin
              // Line full: ring the terminal bell instead of storing.
              ld_s[0]  = 8'h07;
              ld_cnt_s = 3'd1;
            end
          end else if (is_rubout(RX_DATA)) begin
            if (length_r != LW'(0)) begin
              // Byte stays in DATA; only LENGTH shrinks.
              length_nxt_s = length_r - LW'(1);
              ld_s[0]      = 8'h08;
              ld_s[1]      = 8'h20;
              ld_s[2]      = 8'h08;
              ld_cnt_s     = 3'd3;
            end else begin
              ld_cnt_s = 3'd0;
            end
          end else if (RX_DATA == 8'h0D) begin
            ld_s[0]         = 8'h0D;
            ld_s[1]         = 8'h0A;
            ld_cnt_s        = 3'd2;
            line_pend_nxt_s = 1'b1;
          end else if (RX_DATA == 8'h03) begin
            length_nxt_s = LW'(0);
            ld_s[0]      = 8'h5E;
            ld_s[1]      = 8'h43;
            ld_s[2]      = 8'h0D;
            ld_s[3]      = 8'h0A;
            ld_cnt_s     = 3'd4;
          end else begin
            ld_cnt_s = 3'd0;
          end

          if (ld_cnt_s != 3'd0) begin
            state_nxt_s    = ST_TX_REQ;
            tx_req_n_nxt_s = 1'b0;
            tx_data_nxt_s  = ld_s[0];
            q_cnt_nxt_s    = ld_cnt_s;
            for (int i = 0; i < 4; i++) begin
              q_nxt_s[i] = ld_s[i];
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_TX_REQ: begin
        if (!TX_ACK_n) begin
          tx_req_n_nxt_s = 1'b1;
          q_nxt_s[0]     = q_r[1];
          q_nxt_s[1]     = q_r[2];
          q_nxt_s[2]     = q_r[3];
          q_nxt_s[3]     = 8'h00;
          q_cnt_nxt_s    = q_cnt_r - 3'd1;
          state_nxt_s    = ST_TX_REL;
        end else begin
          state_nxt_s = ST_TX_REQ;
        end
      end

      ST_TX_REL: begin
        if (TX_ACK_n) begin
          if (q_cnt_r != 3'd0) begin
            tx_req_n_nxt_s = 1'b0;
            tx_data_nxt_s  = q_r[0];
            state_nxt_s    = ST_TX_REQ;
          end else if (line_pend_r) begin
            line_req_n_nxt_s = 1'b0;
            line_pend_nxt_s  = 1'b0;
            state_nxt_s      = ST_LINE_REQ;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_TX_REL;
        end
      end

      ST_LINE_REQ: begin
        if (!LINE_ACK_n) begin
          line_req_n_nxt_s = 1'b1;
          state_nxt_s      = ST_LINE_REL;
        end else begin
          state_nxt_s = ST_LINE_REQ;
        end
      end

      ST_LINE_REL: begin
        if (LINE_ACK_n) begin
          length_nxt_s = LW'(0);
          state_nxt_s  = ST_IDLE;
        end else begin
          state_nxt_s = ST_LINE_REL;
        end
      end

      default: begin
        state_nxt_s      = ST_IDLE;
        tx_req_n_nxt_s   = 1'b1;
        line_req_n_nxt_s = 1'b1;
        q_cnt_nxt_s      = 3'd0;
        line_pend_nxt_s  = 1'b0;
      end
    endcase
  end

  // State register and registered handshake/control outputs.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r      <= ST_IDLE;
      length_r     <= LW'(0);
      line_pend_r  <= 1'b0;
      tx_req_n_r   <= 1'b1;
      tx_data_r    <= 8'h00;
      line_req_n_r <= 1'b1;
      rx_ready_r   <= 1'b1;
      q_cnt_r      <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        q_r[i] <= 8'h00;
      end
    end else begin
      state_r      <= state_nxt_s;
      length_r     <= length_nxt_s;
      line_pend_r  <= line_pend_nxt_s;
      tx_req_n_r   <= tx_req_n_nxt_s;
      tx_data_r    <= tx_data_nxt_s;
      line_req_n_r <= line_req_n_nxt_s;
      rx_ready_r   <= (state_nxt_s == ST_IDLE);
      q_cnt_r      <= q_cnt_nxt_s;
      for (int i = 0; i < 4; i++) begin
        q_r[i] <= q_nxt_s[i];
      end
    end
  end

  // Line buffer storage; only written by a printable byte accepted in idle.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int i = 0; i < COUNT; i++) begin
        DATA[i] <= 8'h00;
      end
    end else begin
      if (wr_en_s) begin
        DATA[wr_idx_s] <= RX_DATA;
      end else begin
        DATA[wr_idx_s] <= DATA[wr_idx_s];
      end
    end
  end

endmodule

// File: tb/tb_debugger_line_input.sv
// Directed bench for debugger_line_input with a small line buffer (COUNT=4)
// so the full-line bell path is reachable. Responders emulate the UART TX
// side and the command decoder; they record echoed bytes and captured lines.
module tb_debugger_line_input;

  localparam int COUNT = 4;
  localparam int LW    = $clog2(COUNT + 1) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          tx_req_n;
  logic [7:0]    tx_data;
  logic          tx_ack_n;
  logic          line_req_n;
  logic          line_ack_n;
  logic [7:0]    data [0:COUNT-1];
  logic [LW-1:0] length;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] echo_q [$];
  logic [7:0] exp_q  [$];
  logic       tx_hold = 1'b0;
  int         line_cnt = 0;
  logic [LW-1:0] cap_len;
  logic [7:0]    cap_data [0:COUNT-1];

  debugger_line_input #(.COUNT(COUNT)) dut (
    .CLK        (clk),
    .RESET_n    (reset_n),
    .RX_VALID   (rx_valid),
    .RX_DATA    (rx_data),
    .RX_READY   (rx_ready),
    .TX_REQ_n   (tx_req_n),
    .TX_DATA    (tx_data),
    .TX_ACK_n   (tx_ack_n),
    .LINE_REQ_n (line_req_n),
    .LINE_ACK_n (line_ack_n),
    .DATA       (data),
    .LENGTH     (length)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART TX emulation: acknowledge each echo request, record its byte.
  initial begin
    tx_ack_n = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_ack_n && !tx_req_n) begin
        echo_q.push_back(tx_data);
        tx_ack_n = 1'b0;
      end else if (!tx_ack_n && tx_req_n && !tx_hold) begin
        tx_ack_n = 1'b1;
      end
    end
  end

  // Command decoder emulation: capture the presented line, then acknowledge.
  initial begin
    line_ack_n = 1'b1;
    forever begin
      @(negedge clk);
      if (line_ack_n && !line_req_n) begin
        cap_len = length;
        for (int i = 0; i < COUNT; i++) cap_data[i] = data[i];
        line_cnt++;
        line_ack_n = 1'b0;
      end else if (!line_ack_n && line_req_n) begin
        line_ack_n = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] c);
    int w;
    w = 0;
    @(negedge clk);
    while (!rx_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!rx_ready) check_val("rx_ready timeout", {31'd0, rx_ready}, 32'd1);
    rx_valid = 1'b1;
    rx_data  = c;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!(rx_ready && tx_req_n && line_req_n && tx_ack_n && line_ack_n) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) check_val("idle timeout", 32'd0, 32'd1);
  endtask

  task automatic check_echo(input string tag);
    logic [31:0] got;
    check_val({tag, " echo count"}, echo_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < echo_q.size()) ? {24'd0, echo_q[i]} : 32'hFFFF_FFFF;
      check_val($sformatf("%s echo[%0d]", tag, i), got, {24'd0, exp_q[i]});
    end
    echo_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst rx_ready",   {31'd0, rx_ready},   32'd1);
    check_val("rst tx_req_n",   {31'd0, tx_req_n},   32'd1);
    check_val("rst tx_data",    {24'd0, tx_data},    32'd0);
    check_val("rst line_req_n", {31'd0, line_req_n}, 32'd1);
    check_val("rst length",     32'(length),         32'd0);
    check_val("rst data0",      {24'd0, data[0]},    32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: "d 10" CR
    send_str("d 10");
    send_byte(8'h0D);
    wait_idle();
    exp_q = '{8'h64, 8'h20, 8'h31, 8'h30, 8'h0D, 8'h0A};
    check_echo("t1");
    check_val("t1 line_cnt", line_cnt, 32'd1);
    check_val("t1 cap_len", 32'(cap_len), 32'd4);
    check_val("t1 d0", {24'd0, cap_data[0]}, 32'h64);
    check_val("t1 d1", {24'd0, cap_data[1]}, 32'h20);
    check_val("t1 d2", {24'd0, cap_data[2]}, 32'h31);
    check_val("t1 d3", {24'd0, cap_data[3]}, 32'h30);
    check_val("t1 length after", 32'(length), 32'd0);
    check_val("t1 rx_ready after", {31'd0, rx_ready}, 32'd1);

    // 2: "ab" BS "c" CR
    send_str("ab");
    send_byte(8'h08);
    send_byte(8'h63);
    send_byte(8'h0D);
    wait_idle();
    exp_q = '{8'h61, 8'h62, 8'h08, 8'h20, 8'h08, 8'h63, 8'h0D, 8'h0A};
    check_echo("t2");
    check_val("t2 line_cnt", line_cnt, 32'd2);
    check_val("t2 cap_len", 32'(cap_len), 32'd2);
    check_val("t2 d0", {24'd0, cap_data[0]}, 32'h61);
    check_val("t2 d1", {24'd0, cap_data[1]}, 32'h63);

    // 3: BS, DEL at LENGTH 0, then LF: nothing happens
    send_byte(8'h08);
    send_byte(8'h7F);
    send_byte(8'h0A);
    repeat (5) @(negedge clk);
    check_echo("t3");
    check_val("t3 length", 32'(length), 32'd0);
    check_val("t3 rx_ready", {31'd0, rx_ready}, 32'd1);

    // 4: overflow rings the bell, then the full line is delivered
    send_str("12345");
    wait_idle();
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h07};
    check_echo("t4");
    check_val("t4 length full", 32'(length), 32'd4);
    send_byte(8'h0D);
    wait_idle();
    exp_q = '{8'h0D, 8'h0A};
    check_echo("t4 cr");
    check_val("t4 line_cnt", line_cnt, 32'd3);
    check_val("t4 cap_len", 32'(cap_len), 32'd4);
    check_val("t4 d0", {24'd0, cap_data[0]}, 32'h31);
    check_val("t4 d3", {24'd0, cap_data[3]}, 32'h34);

    // 5: "xy" ^C cancels the line
    send_str("xy");
    send_byte(8'h03);
    wait_idle();
    exp_q = '{8'h78, 8'h79, 8'h5E, 8'h43, 8'h0D, 8'h0A};
    check_echo("t5");
    check_val("t5 length", 32'(length), 32'd0);
    check_val("t5 line_cnt", line_cnt, 32'd3);

    // 5b: CR on an empty line still runs the line handshake
    send_byte(8'h0D);
    wait_idle();
    exp_q = '{8'h0D, 8'h0A};
    check_echo("t5b");
    check_val("t5b line_cnt", line_cnt, 32'd4);
    check_val("t5b cap_len", 32'(cap_len), 32'd0);

    // 6: reset in the middle of an echo handshake
    send_str("xy");
    wait_idle();
    exp_q = '{8'h78, 8'h79};
    check_echo("t6 pre");
    check_val("t6 length pre", 32'(length), 32'd2);
    tx_hold = 1'b1;
    send_byte(8'h0D);
    repeat (10) @(negedge clk);
    check_val("t6 stuck tx_req_n", {31'd0, tx_req_n}, 32'd1);
    check_val("t6 stuck rx_ready", {31'd0, rx_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    check_val("t6 rst tx_req_n",   {31'd0, tx_req_n},   32'd1);
    check_val("t6 rst length",     32'(length),         32'd0);
    check_val("t6 rst rx_ready",   {31'd0, rx_ready},   32'd1);
    check_val("t6 rst line_req_n", {31'd0, line_req_n}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    tx_hold = 1'b0;
    repeat (10) @(negedge clk);
    exp_q = '{8'h0D};
    check_echo("t6 post");
    check_val("t6 line_req_n", {31'd0, line_req_n}, 32'd1);
    check_val("t6 line_cnt", line_cnt, 32'd4);
    check_val("t6 rx_ready", {31'd0, rx_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
